// File: rtl/qrd_rls_pkg.sv
// Shared definitions for the QRD-RLS systolic array cells: the boundary-cell
// FSM states, the default word width and the output saturation helper.
package qrd_rls_pkg;

    localparam int DEFAULT_DATA_LENGTH = 8;

    typedef enum logic [2:0] {
        IDLE,
        SQUARE,
        SQRT,
        DIV,
        DONE
    } state_t;

    // Clamp an unsigned value to the largest number that fits in data_length bits.
    function automatic logic [31:0] sat_dl(input logic [31:0] value, input int data_length);
        logic [31:0] limit;
        limit = (32'd1 << data_length) - 32'd1;
        return (value > limit) ? limit : value;
    endfunction

endpackage

// File: rtl/qrd_seq_divider.sv
// Restoring divider producing one quotient bit per cycle, MSB first.
// The first iteration happens on the start edge itself, using the ports
// directly, so a full quotient takes exactly DATA_LENGTH+1 edges. The caller
// guarantees numerator < divisor * 2^(DATA_LENGTH+1), so the upper numerator
// bits are already a valid partial remainder. done is high during the cycle
// whose closing edge latches the final quotient bit.
module qrd_seq_divider #(
    parameter int DATA_LENGTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [2*DATA_LENGTH-1:0]   numerator,
    input  logic [DATA_LENGTH:0]       divisor,
    output logic                       done,
    output logic [DATA_LENGTH:0]       quotient
);

    localparam int QW = DATA_LENGTH + 1;
    localparam int CW = $clog2(QW + 1);

    logic          active_q, active_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [QW-1:0] rem_q, rem_d;
    logic [QW-1:0] bits_q, bits_d;
    logic [QW-1:0] den_q, den_d;
    logic [QW-1:0] quo_q, quo_d;

    logic [QW-1:0] src_rem, src_bits, src_den, src_quo;
    logic [QW:0]   trial, diff;
    logic          ge;

    // One restoring step: bring down the next numerator bit, subtract if it fits.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        src_rem  = start ? QW'(numerator[2*DATA_LENGTH-1:QW]) : rem_q;
        src_bits = start ? numerator[QW-1:0] : bits_q;
        src_den  = start ? divisor : den_q;
        src_quo  = start ? '0 : quo_q;

        trial = {src_rem, src_bits[QW-1]};
        diff  = trial - {1'b0, src_den};
        ge    = (trial >= {1'b0, src_den});

        active_d = active_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        bits_d   = bits_q;
        den_d    = den_q;
        quo_d    = quo_q;

        if (start || active_q) begin
            rem_d  = ge ? diff[QW-1:0] : trial[QW-1:0];
            bits_d = {src_bits[QW-2:0], 1'b0};
            den_d  = src_den;
            quo_d  = {src_quo[QW-2:0], ge};
        end

        if (start) begin
            active_d = 1'b1;
            cnt_d    = CW'(1);
        end else if (active_q) begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(QW - 1)) begin
                active_d = 1'b0;
            end
        end
    end

    assign done     = active_q && (cnt_q == CW'(QW - 1));
    assign quotient = quo_q;

    // Iteration state register.
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_q <= 1'b0;
            cnt_q    <= '0;
            rem_q    <= '0;
            bits_q   <= '0;
            den_q    <= '0;
            quo_q    <= '0;
        end else begin
            active_q <= active_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            bits_q   <= bits_d;
            den_q    <= den_d;
            quo_q    <= quo_d;
        end
    end

endmodule

// File: rtl/inverse_boundary_cell.sv
// Boundary (diagonal) cell of the inverse QRD-RLS array. For each accepted
// sample it forms r' = sqrt(r^2 + x^2), emits the rotation c = r/r',
// s = x/r' as fractions scaled by 2^DATA_LENGTH, and replaces r with r'.
module inverse_boundary_cell
    import qrd_rls_pkg::*;
#(
    parameter int                     DATA_LENGTH = DEFAULT_DATA_LENGTH,
    parameter logic [DATA_LENGTH-1:0] R_INIT      = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ready_in,
    input  logic [DATA_LENGTH-1:0] xin,
    output logic [DATA_LENGTH-1:0] c_out,
    output logic [DATA_LENGTH-1:0] s_out,
    output logic [DATA_LENGTH-1:0] r_out,
    output logic                   ready_out,
    output logic                   busy
);

    localparam int DL = DATA_LENGTH;
    localparam int DW = 2 * DL + 1;        // r^2 + x^2
    localparam int SW = DW + 1;            // sum padded to an even bit count
    localparam int QW = DL + 1;            // root and quotient width
    localparam int RW = DL + 4;            // square-root partial remainder
    localparam int IW = $clog2(DL + 2);

    state_t        state_q, state_d;
    logic [DL-1:0] x_q, x_d;
    logic [DL-1:0] r_q, r_d;
    logic [SW-1:0] sum_sh_q, sum_sh_d;
    logic [RW-1:0] rem_q, rem_d;
    logic [QW-1:0] root_q, root_d;
    logic [IW-1:0] iter_q, iter_d;
    logic [DL-1:0] c_q, c_d;
    logic [DL-1:0] s_q, s_d;
    logic          ready_q, ready_d;

    logic [DW-1:0] sum_w;
    logic [RW-1:0] rem_sh, trial;
    logic [31:0]   c_sat, s_sat, r_sat;
    logic          div_start, div_done_c, div_done_s;
    logic [QW-1:0] quo_c, quo_s;

    qrd_seq_divider #(.DATA_LENGTH(DL)) u_div_c (
        .clk       (clk),
        .rst       (rst),
        .start     (div_start),
        .numerator ({r_q, {DL{1'b0}}}),
        .divisor   (root_q),
        .done      (div_done_c),
        .quotient  (quo_c)
    );

    qrd_seq_divider #(.DATA_LENGTH(DL)) u_div_s (
        .clk       (clk),
        .rst       (rst),
        .start     (div_start),
        .numerator ({x_q, {DL{1'b0}}}),
        .divisor   (root_q),
        .done      (div_done_s),
        .quotient  (quo_s)
    );

    // Next-state and datapath: square, bit-serial root, parallel divides, commit.
    always_comb begin
        sum_w  = DW'(r_q) * DW'(r_q) + DW'(x_q) * DW'(x_q);
        rem_sh = {rem_q[RW-3:0], sum_sh_q[SW-1 -: 2]};
        trial  = RW'({root_q, 2'b01});
        c_sat  = sat_dl(32'(quo_c), DL);
        s_sat  = sat_dl(32'(quo_s), DL);
        r_sat  = sat_dl(32'(root_q), DL);

        state_d   = state_q;
        x_d       = x_q;
        r_d       = r_q;
        sum_sh_d  = sum_sh_q;
        rem_d     = rem_q;
        root_d    = root_q;
        iter_d    = iter_q;
        c_d       = c_q;
        s_d       = s_q;
        ready_d   = 1'b0;
        div_start = 1'b0;

        case (state_q)
            IDLE: begin
                if (ready_in) begin
                    x_d     = xin;
                    state_d = SQUARE;
                end
            end
            SQUARE: begin
                sum_sh_d = {1'b0, sum_w};
                rem_d    = '0;
                root_d   = '0;
                iter_d   = '0;
                state_d  = SQRT;
            end
            SQRT: begin
                sum_sh_d = sum_sh_q << 2;
                if (rem_sh >= trial) begin
                    rem_d  = rem_sh - trial;
                    root_d = {root_q[QW-2:0], 1'b1};
                end else begin
                    rem_d  = rem_sh;
                    root_d = {root_q[QW-2:0], 1'b0};
                end
                if (iter_q == IW'(DL)) begin
                    iter_d  = '0;
                    state_d = DIV;
                end else begin
                    iter_d = iter_q + IW'(1);
                end
            end
            DIV: begin
                div_start = (iter_q == '0);
                iter_d    = iter_q + IW'(1);
                if (div_done_c && div_done_s) begin
                    iter_d  = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                // A zero root means r = x = 0: report the identity rotation.
                if (root_q == '0) begin
                    c_d = '1;
                    s_d = '0;
                end else begin
                    c_d = c_sat[DL-1:0];
                    s_d = s_sat[DL-1:0];
                    r_d = r_sat[DL-1:0];
                end
                ready_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any computation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            x_q      <= '0;
            r_q      <= R_INIT;
            sum_sh_q <= '0;
            rem_q    <= '0;
            root_q   <= '0;
            iter_q   <= '0;
            c_q      <= '0;
            s_q      <= '0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            r_q      <= r_d;
            sum_sh_q <= sum_sh_d;
            rem_q    <= rem_d;
            root_q   <= root_d;
            iter_q   <= iter_d;
            c_q      <= c_d;
            s_q      <= s_d;
            ready_q  <= ready_d;
        end
    end

    assign c_out     = c_q;
    assign s_out     = s_q;
    assign r_out     = r_q;
    assign ready_out = ready_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_inverse_boundary_cell.sv
// Bench for the boundary cell: directed scenarios followed by random samples,
// all checked against an arithmetic model of the rotation.
module tb_inverse_boundary_cell;

    localparam int DL  = 8;
    localparam int MAX = (1 << DL) - 1;
    localparam int LAT = 2 * DL + 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          ready_in;
    logic [DL-1:0] xin;
    logic [DL-1:0] c_out, s_out, r_out;
    logic          ready_out, busy;

    int vectors     = 0;
    int miscompares = 0;
    int model_r     = 0;

    always #5 clk = ~clk;

    inverse_boundary_cell #(
        .DATA_LENGTH (DL),
        .R_INIT      ('0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ready_in  (ready_in),
        .xin       (xin),
        .c_out     (c_out),
        .s_out     (s_out),
        .r_out     (r_out),
        .ready_out (ready_out),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    function automatic int isqrt(input int v);
        int k = 0;
        while ((k + 1) * (k + 1) <= v) k++;
        return k;
    endfunction

    // Reference rotation computed directly from r' = sqrt(r^2 + x^2).
    task automatic model(input int r, input int x, output int c, output int s, output int rn);
        int root;
        root = isqrt(r * r + x * x);
        if (root == 0) begin
            c  = MAX;
            s  = 0;
            rn = r;
        end else begin
            c  = ((r << DL) / root > MAX) ? MAX : (r << DL) / root;
            s  = ((x << DL) / root > MAX) ? MAX : (x << DL) / root;
            rn = (root > MAX) ? MAX : root;
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " c_out"}, 32'(c_out), 0);
        check({tag, " s_out"}, 32'(s_out), 0);
        check({tag, " r_out"}, 32'(r_out), 0);
        check({tag, " ready_out"}, 32'(ready_out), 0);
        check({tag, " busy"}, 32'(busy), 0);
    endtask

    // Entered and left at a falling edge.
    task automatic apply_reset();
        rst      = 1'b1;
        ready_in = 1'b0;
        xin      = '0;
        @(negedge clk);
        @(negedge clk);
        check_reset_values("reset");
        rst     = 1'b0;
        model_r = 0;
        @(negedge clk);
    endtask

    // Offer x for one edge, optionally pulse ready_in (xin=9) on cycles g1/g2
    // while the cell is busy, and check the handshake every cycle up to the result.
    task automatic run_txn(input int x, input int g1, input int g2);
        int ec, es, er;
        model(model_r, x, ec, es, er);
        ready_in = 1'b1;
        xin      = DL'(x);
        @(posedge clk);
        for (int k = 0; k <= LAT; k++) begin
            @(negedge clk);
            check($sformatf("ready_out x=%0d cyc=%0d", x, k), 32'(ready_out), 32'(k == LAT));
            check($sformatf("busy x=%0d cyc=%0d", x, k), 32'(busy), 32'(k < LAT));
            if (k == g1 || k == g2) begin
                ready_in = 1'b1;
                xin      = DL'(9);
            end else begin
                ready_in = 1'b0;
            end
        end
        check($sformatf("c_out r=%0d x=%0d", model_r, x), 32'(c_out), 32'(ec));
        check($sformatf("s_out r=%0d x=%0d", model_r, x), 32'(s_out), 32'(es));
        check($sformatf("r_out r=%0d x=%0d", model_r, x), 32'(r_out), 32'(er));
        model_r = er;
    endtask

    initial begin
        int g;

        // Plan 1 and 2: x=3, x=4, x=0 in sequence from reset.
        apply_reset();
        run_txn(3, -1, -1);
        run_txn(4, -1, -1);
        run_txn(0, -1, -1);

        // Plan 3: full-scale input twice, root exceeds DATA_LENGTH bits.
        apply_reset();
        run_txn(255, -1, -1);
        run_txn(255, -1, -1);

        // Plan 4: zero root path.
        apply_reset();
        run_txn(0, -1, -1);

        // Plan 5: samples offered while busy and during DONE are dropped.
        apply_reset();
        run_txn(3, 4, 19);
        run_txn(5, -1, -1);
        @(negedge clk);
        check("idle after dropped samples busy", 32'(busy), 0);

        // Plan 6: asynchronous reset during the square root.
        apply_reset();
        ready_in = 1'b1;
        xin      = DL'(4);
        @(posedge clk);
        for (int k = 0; k <= 5; k++) begin
            @(negedge clk);
            ready_in = 1'b0;
        end
        check("busy before abort", 32'(busy), 1);
        #2 rst = 1'b1;
        #1 check_reset_values("async abort");
        @(negedge clk);
        rst     = 1'b0;
        model_r = 0;
        for (int k = 0; k < LAT + 4; k++) begin
            @(negedge clk);
            check($sformatf("no pulse after abort cyc=%0d", k), 32'(ready_out), 0);
        end
        run_txn(4, -1, -1);

        // Random samples with random dropped offers, accumulating r.
        apply_reset();
        for (int n = 0; n < 24; n++) begin
            g = (n % 3 == 0) ? int'($urandom_range(1, LAT - 1)) : -1;
            run_txn(int'($urandom_range(0, MAX)), g, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/inverse_boundary_cell.md
Name: inverse_boundary_cell

Overview:
- Diagonal (boundary) cell of the inverse QRD-RLS systolic array.
- Generates the Givens rotation (c, s) consumed by the internal cells to its right.
- Holds the diagonal element r. For each new xin it computes r' = sqrt(r² + xin²), c = r/r', s = xin/r', then updates r.
- Arithmetic is multi-cycle: a sequential integer square root followed by two parallel restoring dividers, controlled by an FSM.

Parameters:
- DATA_LENGTH, 8, width of xin, r, c_out, s_out.
- R_INIT, 0, reset value of stored r (DATA_LENGTH bits).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- ready_in  input  1  xin valid; sampled only in IDLE.
- xin  input  DATA_LENGTH  unsigned input sample from the cell above.
- c_out  output  DATA_LENGTH  cosine, unsigned fraction scaled by 2^DATA_LENGTH, saturated.
- s_out  output  DATA_LENGTH  sine, same format.
- r_out  output  DATA_LENGTH  current stored r.
- ready_out  output  1  one-cycle pulse when c_out/s_out/r_out are updated.
- busy  output  1  high whenever state ≠ IDLE.

Behaviour:
- Reset (async, immediate): state=IDLE, r=R_INIT, c_out=0, s_out=0, r_out=R_INIT, ready_out=0, busy=0. All iteration counters and datapath registers are cleared. Reset mid-operation aborts the computation and no ready_out is produced.
- FSM states: IDLE, SQUARE, SQRT, DIV, DONE.
- IDLE: if ready_in=1 at edge E0, capture xin into x_reg and go to SQUARE. Otherwise stay.
- SQUARE (1 cycle): sum = r·r + x_reg·x_reg, 2·DATA_LENGTH+1 bits. Go to SQRT.
- SQRT (DATA_LENGTH+1 cycles): restoring bit-serial integer square root, one result bit per cycle, MSB first. Produces root = floor(sqrt(sum)), DATA_LENGTH+1 bits. Go to DIV.
- DIV (DATA_LENGTH+1 cycles): two restoring dividers run in parallel:
  - qc = floor((r << DATA_LENGTH) / root)
  - qs = floor((x_reg << DATA_LENGTH) / root)
  - Each quotient is DATA_LENGTH+1 bits. Go to DONE.
- DONE (1 cycle), on the edge leaving DONE:
  - c_out = min(qc, 2^DATA_LENGTH−1); s_out = min(qs, 2^DATA_LENGTH−1).
  - r = r_out = min(root, 2^DATA_LENGTH−1).
  - ready_out=1 for exactly one cycle. Go to IDLE.
- root=0 (r=0 and xin=0): skip the divide results; c_out=2^DATA_LENGTH−1, s_out=0, r unchanged at 0. Timing is identical to the normal path.
- Latency: ready_out is high in the cycle after edge E0+2·DATA_LENGTH+4 (20 edges for DATA_LENGTH=8).
- Throughput: earliest next accept is at E0+2·DATA_LENGTH+5.
- ready_in while busy=1 is ignored: the sample is dropped and there is no queueing. ready_in in the DONE cycle is also ignored.
- c_out, s_out, r_out hold their values between updates. ready_out is 0 in every cycle except the DONE-exit pulse.
- All arithmetic is unsigned. r ≤ root always holds, so qc ≤ 2^DATA_LENGTH; saturation handles qc = 2^DATA_LENGTH (xin=0) and qs = 2^DATA_LENGTH (r=0).

Decomposition:
- Shared package qrd_rls_pkg holds:
  - the FSM state enum (IDLE, SQUARE, SQRT, DIV, DONE);
  - the default DATA_LENGTH;
  - function sat_dl() (clamp to 2^DATA_LENGTH−1).
- Sub-module qrd_seq_divider: restoring divider with start/done, numerator 2·DATA_LENGTH bits, divisor and quotient DATA_LENGTH+1 bits, DATA_LENGTH+1 cycles.
  - Instantiated twice (c path, s path).
  - Square root is implemented inline in the cell.

Test Plan (DATA_LENGTH=8, R_INIT=0):
1. Reset, then ready_in pulse with xin=3 → 20 cycles later ready_out pulse; c_out=0, s_out=255 (256 saturated), r_out=3; busy high for 20 cycles.
2. Continuing from 1, xin=4 → sum=25, root=5; c_out=153, s_out=204, r_out=5. Then xin=0 → c_out=255, s_out=0, r_out=5.
3. From reset, xin=255 twice → first result c=0, s=255, r=255; second: sum=130050, root=360, c_out=181, s_out=181, r_out=255 (saturated).
4. From reset, xin=0 → root=0 path: c_out=255, s_out=0, r_out=0; ready_out still at 20 cycles.
5. Accept xin=3, then assert ready_in with xin=9 on cycles 5 and 19 → both ignored; single ready_out with r_out=3; next accept succeeds at cycle 21.
6. Accept xin=4, assert rst asynchronously during SQRT → outputs return to reset values immediately, busy=0, no ready_out pulse. A following xin=4 yields c_out=0, s_out=255, r_out=4.
